escaner_teclado: RTL

ESCANER_TECLADO -- requirements
Module: escaner_teclado

---
 rtl/teclado_pkg.sv | 39 +++
 rtl/generador_tick.sv | 24 ++
 rtl/escaner_teclado.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/teclado_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, key map and
// default timing parameters.
package teclado_pkg;

    localparam int unsigned SCAN_BITS_DEF = 16;
    localparam int unsigned DEB_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } estado_e;

    // Row-major key layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    function automatic logic [3:0] mapa_tecla(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] codigo;
        case ({fila, col})
            4'd0:    codigo = 4'h1;
            4'd1:    codigo = 4'h2;
            4'd2:    codigo = 4'h3;
            4'd3:    codigo = 4'hA;
            4'd4:    codigo = 4'h4;
            4'd5:    codigo = 4'h5;
            4'd6:    codigo = 4'h6;
            4'd7:    codigo = 4'hB;
            4'd8:    codigo = 4'h7;
            4'd9:    codigo = 4'h8;
            4'd10:   codigo = 4'h9;
            4'd11:   codigo = 4'hC;
            4'd12:   codigo = 4'hE;
            4'd13:   codigo = 4'h0;
            4'd14:   codigo = 4'hF;
            default: codigo = 4'hD;
        endcase
        return codigo;
    endfunction

endpackage

// File: rtl/generador_tick.sv
// Free-running prescaler; tick strobes for one cycle whenever the count is all ones.
module generador_tick
    import teclado_pkg::*;
#(
    parameter int unsigned SCAN_BITS = SCAN_BITS_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [SCAN_BITS-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + SCAN_BITS'(1);
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: column rotation, debounced press/release detection and
// a four-digit history of accepted keys.
module escaner_teclado
    import teclado_pkg::*;
#(
    parameter int unsigned SCAN_BITS = SCAN_BITS_DEF,
    parameter int unsigned DEB_COUNT = DEB_COUNT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  filas,
    output logic [3:0]  columnas,
    output logic [3:0]  tecla,
    output logic        tecla_valida,
    output logic        tecla_presionada,
    output logic [15:0] digitos
);

    localparam int unsigned CW = $clog2(DEB_COUNT + 1);

    logic          tick;
    logic [3:0]    sync1_q, filas_s;
    estado_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    fila_q, fila_d;
    logic [3:0]    col_q, col_d, col_rot;
    logic [3:0]    tecla_q, tecla_d;
    logic          valida_q, valida_d;
    logic          pres_q, pres_d;
    logic [15:0]   dig_q, dig_d;
    logic          unica_c, libre_c, misma_c, aceptar_c, liberar_c;
    logic [1:0]    fila_idx_c, col_idx_c;

    generador_tick #(.SCAN_BITS(SCAN_BITS)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Row decode: exactly one low row is a valid single key.
    always_comb begin
        unica_c    = 1'b1;
        fila_idx_c = 2'd0;
        case (filas_s)
            4'b1110: fila_idx_c = 2'd0;
            4'b1101: fila_idx_c = 2'd1;
            4'b1011: fila_idx_c = 2'd2;
            4'b0111: fila_idx_c = 2'd3;
            default: unica_c = 1'b0;
        endcase
        col_idx_c = 2'd0;
        case (col_q)
            4'b1101: col_idx_c = 2'd1;
            4'b1011: col_idx_c = 2'd2;
            4'b0111: col_idx_c = 2'd3;
            default: col_idx_c = 2'd0;
        endcase
    end

    assign libre_c = (filas_s == 4'hF);
    assign misma_c = (filas_s == ~(4'b0001 << fila_q));
    assign cnt_inc = cnt_q + CW'(1);
    assign col_rot = {col_q[2:0], col_q[3]};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 4'hF;
            filas_s  <= 4'hF;
            state_q  <= ST_SCAN;
            cnt_q    <= '0;
            fila_q   <= '0;
            col_q    <= 4'b1110;
            tecla_q  <= '0;
            valida_q <= 1'b0;
            pres_q   <= 1'b0;
            dig_q    <= '0;
        end else begin
            sync1_q  <= filas;
            filas_s  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fila_q   <= fila_d;
            col_q    <= col_d;
            tecla_q  <= tecla_d;
            valida_q <= valida_d;
            pres_q   <= pres_d;
            dig_q    <= dig_d;
        end
    end

    // Next-state: all decisions happen only on the scan tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fila_d    = fila_q;
        col_d     = col_q;
        aceptar_c = 1'b0;
        liberar_c = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (unica_c) begin
                        fila_d = fila_idx_c;
                        cnt_d  = CW'(1);
                        if (DEB_COUNT <= 1) begin
                            state_d   = ST_HELD;
                            aceptar_c = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_rot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (misma_c) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CW'(DEB_COUNT)) begin
                            state_d   = ST_HELD;
                            aceptar_c = 1'b1;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        col_d   = col_rot;
                    end
                end
                ST_HELD: begin
                    if (libre_c) begin
                        cnt_d = CW'(1);
                        if (DEB_COUNT <= 1) begin
                            state_d   = ST_SCAN;
                            col_d     = col_rot;
                            liberar_c = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                default: begin
                    if (libre_c) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CW'(DEB_COUNT)) begin
                            state_d   = ST_SCAN;
                            col_d     = col_rot;
                            liberar_c = 1'b1;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            endcase
        end
    end

    // Output next values: pulse, code and history update on acceptance.
    always_comb begin
        valida_d = aceptar_c;
        tecla_d  = tecla_q;
        dig_d    = dig_q;
        pres_d   = pres_q;
        if (aceptar_c) begin
            tecla_d = mapa_tecla(fila_d, col_idx_c);
            dig_d   = {dig_q[11:0], mapa_tecla(fila_d, col_idx_c)};
            pres_d  = 1'b1;
        end else if (liberar_c) begin
            pres_d = 1'b0;
        end
    end

    assign columnas         = col_q;
    assign tecla            = tecla_q;
    assign tecla_valida     = valida_q;
    assign tecla_presionada = pres_q;
    assign digitos          = dig_q;

endmodule
